// File: rtl/regfile_sb_pkg.sv
// Shared register-index types plus the scoreboard's local types and helpers.
// rv32i_types is common to the whole core; regfile_sb_pkg adds what only this block needs.
package rv32i_types;
  typedef logic [4:0] rv32i_reg;
  localparam rv32i_reg REG_X0 = 5'd0;
endpackage

package regfile_sb_pkg;
  import rv32i_types::*;

  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_UP,
    CNT_DOWN,
    CNT_CLEAR
  } cnt_op_e;

  // True when this cycle's writeback targets a real register matching idx.
  function automatic logic bypassHit(input logic load, input rv32i_reg wbIdx,
                                     input rv32i_reg idx);
    return load && (wbIdx == idx) && (idx != REG_X0);
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle of the register file: read ports, issue, commit and status.
interface regfile_sb_if
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
);
  rv32i_reg           rs1;
  rv32i_reg           rs2;
  logic               use_rs1;
  logic               use_rs2;
  logic [WIDTH-1:0]   reg_a;
  logic [WIDTH-1:0]   reg_b;
  logic               issue_valid;
  rv32i_reg           issue_rd;
  logic               stall;
  logic               load_regfile;
  rv32i_reg           rd_wb;
  logic [WIDTH-1:0]   wb_data;
  logic               flush;
  logic               sb_err;

  modport master (
    output rs1, rs2, use_rs1, use_rs2, issue_valid, issue_rd,
           load_regfile, rd_wb, wb_data, flush,
    input  reg_a, reg_b, stall, sb_err
  );

  modport slave (
    input  rs1, rs2, use_rs1, use_rs2, issue_valid, issue_rd,
           load_regfile, rd_wb, wb_data, flush,
    output reg_a, reg_b, stall, sb_err
  );
endinterface

// File: rtl/regfile_sb_counter.sv
// sb_counter: saturating in-flight write counter for one register, with clear.
// o_err pulses for the cycle in which an increment or decrement would wrap.
module sb_counter
  import regfile_sb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  cnt_op_e          w_op;
  logic [CNT_W-1:0] r_cnt;

  // An issue and a retire on the same register cancel out; clear wins over both.
  always_comb begin
    w_op = CNT_HOLD;
    if (i_clr) begin
      w_op = CNT_CLEAR;
    end else if (i_inc && !i_dec) begin
      w_op = CNT_UP;
    end else if (i_dec && !i_inc) begin
      w_op = CNT_DOWN;
    end
  end

  assign o_err = ((w_op == CNT_UP)   && (r_cnt == CntMax)) ||
                 ((w_op == CNT_DOWN) && (r_cnt == '0));
  assign o_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case (w_op)
        CNT_CLEAR: r_cnt <= '0;
        CNT_UP:    if (r_cnt != CntMax) r_cnt <= r_cnt + CntOne;
        CNT_DOWN:  if (r_cnt != '0) r_cnt <= r_cnt - CntOne;
        default:   r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: architectural register file with bypassed reads and a per-register
// count of issued-but-unretired writes that drives the decode stall.
module regfile_sb
  import rv32i_types::*;
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0]    r_regs [NUM_REGS];
  logic [CNT_W-1:0]    w_cnt  [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [NUM_REGS-1:0] w_err;
  logic                r_sbErr;

  logic                w_wbEn;
  logic                w_issueEn;
  logic                w_hitA;
  logic                w_hitB;
  logic                w_hitIssue;
  logic                w_pendA;
  logic                w_pendB;
  logic                w_issueFull;
  logic                w_stall;

  assign w_wbEn     = bus.load_regfile && (bus.rd_wb != REG_X0);
  assign w_issueEn  = bus.issue_valid && (bus.issue_rd != REG_X0);
  assign w_hitA     = bypassHit(bus.load_regfile, bus.rd_wb, bus.rs1);
  assign w_hitB     = bypassHit(bus.load_regfile, bus.rd_wb, bus.rs2);
  assign w_hitIssue = bypassHit(bus.load_regfile, bus.rd_wb, bus.issue_rd);

  // A register whose last outstanding write retires this cycle is served by the bypass.
  assign w_pendA = (bus.rs1 != REG_X0) &&
                   (w_cnt[bus.rs1] != {{(CNT_W-1){1'b0}}, w_hitA});
  assign w_pendB = (bus.rs2 != REG_X0) &&
                   (w_cnt[bus.rs2] != {{(CNT_W-1){1'b0}}, w_hitB});
  assign w_issueFull = w_issueEn && (w_cnt[bus.issue_rd] == CntMax) && !w_hitIssue;

  assign w_stall = (bus.use_rs1 && w_pendA) || (bus.use_rs2 && w_pendB) || w_issueFull;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_issueEn && !w_stall) begin
      w_inc[bus.issue_rd] = 1'b1;
    end
    if (w_wbEn) begin
      w_dec[bus.rd_wb] = 1'b1;
    end
    w_inc[0] = 1'b0;
    w_dec[0] = 1'b0;
  end

  assign w_cnt[0] = '0;
  assign w_err[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (bus.flush),
      .i_inc (w_inc[g]),
      .i_dec (w_dec[g]),
      .o_cnt (w_cnt[g]),
      .o_err (w_err[g])
    );
  end

  assign bus.reg_a = (bus.rs1 == REG_X0) ? '0 :
                     w_hitA ? bus.wb_data : r_regs[bus.rs1];
  assign bus.reg_b = (bus.rs2 == REG_X0) ? '0 :
                     w_hitB ? bus.wb_data : r_regs[bus.rs2];
  assign bus.stall  = w_stall;
  assign bus.sb_err = r_sbErr;

  // Commits land in the array regardless of flush or counter errors; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wbEn) begin
      r_regs[bus.rd_wb] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sbErr <= 1'b0;
    end else if (|w_err) begin
      r_sbErr <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations, then random
// traffic, all continuously compared against an array-based model of the register file.
module tb_regfile_sb;
  localparam int WIDTH = 32;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(WIDTH)) bus ();

  regfile_sb #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mRegs [32];
  int          mCnt  [32];
  bit          mErr = 1'b0;
  bit          modelValid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mRead(input int idx);
    if (idx == 0) return 32'h0;
    if (bus.load_regfile && int'(bus.rd_wb) == idx) return bus.wb_data;
    return mRegs[idx];
  endfunction

  function automatic bit mPend(input int idx);
    int hit;
    if (idx == 0) return 1'b0;
    hit = (bus.load_regfile && int'(bus.rd_wb) == idx) ? 1 : 0;
    return (mCnt[idx] - hit) != 0;
  endfunction

  function automatic bit mStall();
    int  ir;
    bit  full;
    ir   = int'(bus.issue_rd);
    full = bus.issue_valid && ir != 0 && mCnt[ir] == CMAX &&
           !(bus.load_regfile && int'(bus.rd_wb) == ir);
    return (bus.use_rs1 && mPend(int'(bus.rs1))) ||
           (bus.use_rs2 && mPend(int'(bus.rs2))) || full;
  endfunction

  // Compare every cycle mid-period, then advance the model to the next edge.
  always @(negedge clk) begin : cmp
    int ir;
    int wr;
    bit st;
    bit inc;
    bit dec;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mRegs[i] = 32'h0;
        mCnt[i]  = 0;
      end
      mErr       = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      checkOutput("model reg_a",  bus.reg_a, mRead(int'(bus.rs1)));
      checkOutput("model reg_b",  bus.reg_b, mRead(int'(bus.rs2)));
      checkOutput("model stall",  32'(bus.stall), 32'(mStall()));
      checkOutput("model sb_err", 32'(bus.sb_err), 32'(mErr));
      ir  = int'(bus.issue_rd);
      wr  = int'(bus.rd_wb);
      st  = mStall();
      inc = bus.issue_valid && ir != 0 && !st;
      dec = bus.load_regfile && wr != 0;
      if (dec) mRegs[wr] = bus.wb_data;
      if (bus.flush) begin
        for (int i = 0; i < 32; i++) mCnt[i] = 0;
      end else if (!(inc && dec && ir == wr)) begin
        if (inc) begin
          if (mCnt[ir] == CMAX) mErr = 1'b1;
          else mCnt[ir]++;
        end
        if (dec) begin
          if (mCnt[wr] == 0) mErr = 1'b1;
          else mCnt[wr]--;
        end
      end
    end
  end

  task automatic applyStimulus(input int rs1, input bit u1, input int rs2, input bit u2,
                               input bit iv, input int ird, input bit ld, input int rdwb,
                               input logic [31:0] data, input bit fl);
    @(posedge clk);
    #1;
    bus.rs1          = 5'(rs1);
    bus.use_rs1      = u1;
    bus.rs2          = 5'(rs2);
    bus.use_rs2      = u2;
    bus.issue_valid  = iv;
    bus.issue_rd     = 5'(ird);
    bus.load_regfile = ld;
    bus.rd_wb        = 5'(rdwb);
    bus.wb_data      = data;
    bus.flush        = fl;
    #2;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.use_rs1 = 1'b0; bus.use_rs2 = 1'b0; bus.issue_valid = 1'b0;
    bus.load_regfile = 1'b0; bus.flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.rs1 = '0; bus.rs2 = '0; bus.use_rs1 = 1'b0; bus.use_rs2 = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.load_regfile = 1'b0;
    bus.rd_wb = '0; bus.wb_data = '0; bus.flush = 1'b0;
    doReset(2);

    applyStimulus(5, 0, 31, 0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("reset reg_a", bus.reg_a, 32'h0);
    checkOutput("reset reg_b", bus.reg_b, 32'h0);
    checkOutput("reset stall", 32'(bus.stall), 32'h0);
    checkOutput("reset sb_err", 32'(bus.sb_err), 32'h0);

    applyStimulus(3, 1, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 0);
    checkOutput("x3 bypass", bus.reg_a, 32'hDEADBEEF);
    applyStimulus(3, 1, 0, 0, 0, 0, 1, 0, 32'h123, 0);
    checkOutput("x3 array", bus.reg_a, 32'hDEADBEEF);
    checkOutput("x0 no bypass", bus.reg_b, 32'h0);
    checkOutput("x3 underflow err", 32'(bus.sb_err), 32'h1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("x0 reads zero", bus.reg_a, 32'h0);

    doReset(1);
    applyStimulus(0, 0, 0, 0, 1, 7, 0, 0, 32'h0, 0);
    checkOutput("issue x7 stall", 32'(bus.stall), 32'h0);
    applyStimulus(7, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("x7 pending stall", 32'(bus.stall), 32'h1);
    applyStimulus(7, 1, 0, 0, 0, 0, 1, 7, 32'h12, 0);
    checkOutput("x7 wb stall", 32'(bus.stall), 32'h0);
    checkOutput("x7 wb bypass", bus.reg_a, 32'h12);
    applyStimulus(7, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("x7 after wb", bus.reg_a, 32'h12);
    checkOutput("x7 no err", 32'(bus.sb_err), 32'h0);

    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 0);
      checkOutput("x9 issue", 32'(bus.stall), 32'h0);
    end
    applyStimulus(0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 0);
    checkOutput("x9 full stall", 32'(bus.stall), 32'h1);
    applyStimulus(0, 0, 0, 0, 1, 9, 1, 9, 32'h90, 0);
    checkOutput("x9 full with wb", 32'(bus.stall), 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 0);
    checkOutput("x9 still full", 32'(bus.stall), 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(9, 1, 0, 0, 0, 0, 1, 9, 32'h91 + 32'(k), 0);
      checkOutput("x9 drain stall", 32'(bus.stall), (k == 2) ? 32'h0 : 32'h1);
    end
    applyStimulus(9, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("x9 drained", 32'(bus.stall), 32'h0);
    checkOutput("x9 value", bus.reg_a, 32'h93);
    checkOutput("x9 no err", 32'(bus.sb_err), 32'h0);

    applyStimulus(0, 0, 0, 0, 1, 4, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 1, 6, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    applyStimulus(4, 1, 6, 1, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("post flush stall", 32'(bus.stall), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 32'h44, 0);
    checkOutput("pre underflow err", 32'(bus.sb_err), 32'h0);
    idle();
    checkOutput("flush underflow err", 32'(bus.sb_err), 32'h1);
    idle();
    checkOutput("err sticky", 32'(bus.sb_err), 32'h1);

    doReset(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 32'h55, 0);
    applyStimulus(0, 0, 0, 0, 1, 10, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 1, 10, 0, 0, 32'h0, 0);
    applyStimulus(10, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("x10 pending", 32'(bus.stall), 32'h1);
    checkOutput("x10 value", bus.reg_a, 32'h55);
    doReset(1);
    applyStimulus(10, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("x10 reset value", bus.reg_a, 32'h0);
    checkOutput("x10 reset stall", 32'(bus.stall), 32'h0);
    checkOutput("x10 reset err", 32'(bus.sb_err), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst              = ($urandom_range(0, 299) == 0);
      bus.flush        = ($urandom_range(0, 39) == 0);
      bus.rs1          = pick();
      bus.rs2          = pick();
      bus.use_rs1      = 1'($urandom_range(0, 1));
      bus.use_rs2      = 1'($urandom_range(0, 1));
      bus.issue_valid  = 1'($urandom_range(0, 1));
      bus.issue_rd     = pick();
      bus.rd_wb        = pick();
      bus.wb_data      = $urandom;
      bus.load_regfile = ($urandom_range(0, 1) == 1) &&
                         (mCnt[int'(bus.rd_wb)] != 0 || $urandom_range(0, 19) == 0);
    end
    doReset(1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
